wavetable_addr_gen: RTL and testbench

- Multi-voice wavetable address generator. Each channel steps a read address through one stored waveform period, with an optional octave shift.
- Successor to the single-voice sample-address counter. Adds: parametrised width and voice count, clock-enable stepping, per-voice restart and enable, glitch-free period/mode update, and a wrap pulse.
- Sits between the note decoder (period and octave per voice) and the wavetable ROM/mixer read ports.

---
 rtl/wavetable_pkg.sv | 39 +++
 rtl/wavetable_addr_chan.sv | 78 +++++++
 rtl/wavetable_addr_gen.sv | 46 ++++
 tb/tb_wavetable_addr_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/wavetable_pkg.sv
// Shared types, default widths and period-length helper for the
// wavetable address generator.
//   octave_t    : per-voice octave shift selector
//   period_len  : period length L of a voice from its base period P and mode
package wavetable_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int ADDR_W_DEF = 10;
  localparam int LEN_W      = 32;

  typedef enum logic [1:0] {
    OCT_UP1  = 2'd0,
    OCT_NORM = 2'd1,
    OCT_DN1  = 2'd2,
    OCT_DN2  = 2'd3
  } octave_t;

  // Computed at 32 bits so that 4*(P+1) never overflows for any supported
  // ADDR_W; callers zero-extend P into this width.
  function automatic logic [LEN_W-1:0] period_len(input logic [LEN_W-1:0] p,
                                                  input octave_t mode);
    logic [LEN_W-1:0] n;
    logic [LEN_W-1:0] l;
    n = p + 32'd1;
    l = n;
    case (mode)
      OCT_UP1: begin
        l = n >> 1;
        if (l == 32'd0) l = 32'd1;
      end
      OCT_NORM: l = n;
      OCT_DN1:  l = n << 1;
      OCT_DN2:  l = n << 2;
      default:  l = n;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/wavetable_addr_chan.sv
// One wavetable voice: latches period/mode, steps the read address and
// flags the return to 0.
//   clk, rst    : clock, async active-high reset
//   step_en     : sample strobe
//   ch_en       : voice enable (address forced to 0 when low)
//   restart     : synchronous restart pulse
//   max_count   : live base period last index P
//   octave      : live octave_t
//   addr        : registered read address
//   wrap        : one-cycle pulse on a step that returns addr to 0
module wavetable_addr_chan
  import wavetable_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OUT_W  = ADDR_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_en,
  input  logic              ch_en,
  input  logic              restart,
  input  logic [ADDR_W-1:0] max_count,
  input  logic [1:0]        octave,
  output logic [OUT_W-1:0]  addr,
  output logic              wrap
);

  logic [OUT_W-1:0]  addr_q, addr_d;
  logic              wrap_q, wrap_d;
  logic [ADDR_W-1:0] p_q, p_d;
  octave_t           mode_q, mode_d;
  logic [LEN_W-1:0]  len;
  logic              at_last;

  // Length comes only from the latched values, so a live period change can
  // never shorten the period under a running address.
  assign len     = period_len(LEN_W'(p_q), mode_q);
  assign at_last = (LEN_W'(addr_q) == (len - 32'd1));

  always_comb begin
    addr_d = addr_q;
    wrap_d = 1'b0;
    p_d    = p_q;
    mode_d = mode_q;
    if (!ch_en || restart) begin
      addr_d = '0;
      p_d    = max_count;
      mode_d = octave_t'(octave);
    end else if (step_en) begin
      if (at_last) begin
        addr_d = '0;
        wrap_d = 1'b1;
        p_d    = max_count;
        mode_d = octave_t'(octave);
      end else begin
        addr_d = addr_q + OUT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      wrap_q <= 1'b0;
      p_q    <= '0;
      mode_q <= OCT_NORM;
    end else begin
      addr_q <= addr_d;
      wrap_q <= wrap_d;
      p_q    <= p_d;
      mode_q <= mode_d;
    end
  end

  assign addr = addr_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/wavetable_addr_gen.sv
// Multi-voice wavetable address generator: NUM_CH independent voices, each
// stepping a read address through one (octave-shifted) waveform period.
//   sample_adjust_clk : clock
//   Reset             : async active-high reset
//   step_en           : shared sample strobe
//   ch_en, restart    : per-voice enable and restart
//   max_count         : per-voice P, ADDR_W bits each
//   octave            : per-voice octave_t, 2 bits each
//   addr_counter      : per-voice read address, OUT_W bits each
//   wrap              : per-voice wrap pulse
module wavetable_addr_gen
  import wavetable_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OUT_W  = ADDR_W + 2
) (
  input  logic                    sample_adjust_clk,
  input  logic                    Reset,
  input  logic                    step_en,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       restart,
  input  logic [NUM_CH*ADDR_W-1:0] max_count,
  input  logic [NUM_CH*2-1:0]     octave,
  output logic [NUM_CH*OUT_W-1:0] addr_counter,
  output logic [NUM_CH-1:0]       wrap
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wavetable_addr_chan #(
      .ADDR_W (ADDR_W),
      .OUT_W  (OUT_W)
    ) u_chan (
      .clk       (sample_adjust_clk),
      .rst       (Reset),
      .step_en   (step_en),
      .ch_en     (ch_en[i]),
      .restart   (restart[i]),
      .max_count (max_count[i*ADDR_W +: ADDR_W]),
      .octave    (octave[i*2 +: 2]),
      .addr      (addr_counter[i*OUT_W +: OUT_W]),
      .wrap      (wrap[i])
    );
  end

endmodule

// File: tb/tb_wavetable_addr_gen.sv
module tb_wavetable_addr_gen;

  localparam int NCH = 4;
  localparam int AW  = 10;
  localparam int OW  = AW + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             step_en;
  logic [NCH-1:0]   ch_en;
  logic [NCH-1:0]   restart;
  logic [NCH*AW-1:0] max_count;
  logic [NCH*2-1:0] octave;
  logic [NCH*OW-1:0] addr_counter;
  logic [NCH-1:0]   wrap;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_addr [NCH];
  int m_p    [NCH];
  int m_mode [NCH];
  bit m_wrap [NCH];

  wavetable_addr_gen #(.NUM_CH(NCH), .ADDR_W(AW), .OUT_W(OW)) dut (
    .sample_adjust_clk (clk),
    .Reset             (rst),
    .step_en           (step_en),
    .ch_en             (ch_en),
    .restart           (restart),
    .max_count         (max_count),
    .octave            (octave),
    .addr_counter      (addr_counter),
    .wrap              (wrap)
  );

  always #5 clk = ~clk;

  function automatic int period(int p, int mode);
    int l;
    case (mode)
      0: begin l = (p + 1) / 2; if (l < 1) l = 1; end
      1: l = p + 1;
      2: l = 2 * (p + 1);
      default: l = 4 * (p + 1);
    endcase
    return l;
  endfunction

  always @(posedge clk or posedge rst) begin
    int len;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_addr[c] = 0; m_wrap[c] = 0; m_p[c] = 0; m_mode[c] = 1;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        len = period(m_p[c], m_mode[c]);
        m_wrap[c] = 0;
        if (!ch_en[c] || restart[c]) begin
          m_addr[c] = 0;
          m_p[c] = int'(max_count[c*AW +: AW]);
          m_mode[c] = int'(octave[c*2 +: 2]);
        end else if (step_en) begin
          if (m_addr[c] == len - 1) begin
            m_addr[c] = 0;
            m_wrap[c] = 1;
            m_p[c] = int'(max_count[c*AW +: AW]);
            m_mode[c] = int'(octave[c*2 +: 2]);
          end else begin
            m_addr[c] = m_addr[c] + 1;
          end
        end
      end
    end
  end

  // every-cycle compare against the model
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (int'(addr_counter[c*OW +: OW]) != m_addr[c]) begin
        errors++;
        $display("FAIL cmp_addr ch%0d t=%0t got %0d want %0d", c, $time,
                 addr_counter[c*OW +: OW], m_addr[c]);
      end
      checks++;
      if (wrap[c] !== m_wrap[c]) begin
        errors++;
        $display("FAIL cmp_wrap ch%0d t=%0t got %0b want %0b", c, $time, wrap[c], m_wrap[c]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(int c, int p, int m);
    max_count[c*AW +: AW] = AW'(p);
    octave[c*2 +: 2] = 2'(m);
  endtask

  // literal expectation; pins both the DUT and the model
  task automatic lit(string nm, int c, int ea, int ew);
    int ga;
    ga = int'(addr_counter[c*OW +: OW]);
    checks++;
    if (ga != ea || int'(wrap[c]) != ew) begin
      errors++;
      $display("FAIL %s ch%0d got addr %0d wrap %0b want addr %0d wrap %0d",
               nm, c, ga, wrap[c], ea, ew);
    end
    checks++;
    if (m_addr[c] != ea || int'(m_wrap[c]) != ew) begin
      errors++;
      $display("FAIL %s_model ch%0d got addr %0d wrap %0b want addr %0d wrap %0d",
               nm, c, m_addr[c], m_wrap[c], ea, ew);
    end
  endtask

  initial begin
    int k;
    int nwrap;
    int wrap_at;
    rst = 1'b1; step_en = 0; ch_en = '0; restart = '0; max_count = '0; octave = '0;
    #1;
    for (int c = 0; c < NCH; c++) lit("reset", c, 0, 0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // ch0 P=3 NORM, ch1 P=7 UP1, ch2 P=1 DN2
    set_ch(0, 3, 1); set_ch(1, 7, 0); set_ch(2, 1, 3); set_ch(3, 0, 1);
    ch_en = 4'b0111; restart = 4'b0111;
    cyc();
    lit("restart0", 0, 0, 0);
    restart = '0; step_en = 1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      lit("norm_p3", 0, i % 4, (i % 4 == 0) ? 1 : 0);
      lit("up1_p7",  1, i % 4, (i % 4 == 0) ? 1 : 0);
      lit("dn2_p1",  2, i % 8, (i % 8 == 0) ? 1 : 0);
    end

    // glitch-free period change mid-period
    step_en = 0; set_ch(0, 5, 1); restart[0] = 1;
    cyc(); restart[0] = 0; step_en = 1;
    cyc(); cyc(); cyc();
    lit("pre_change", 0, 3, 0);
    set_ch(0, 2, 1);
    cyc(); lit("old_p_4", 0, 4, 0);
    cyc(); lit("old_p_5", 0, 5, 0);
    cyc(); lit("old_p_wrap", 0, 0, 1);
    cyc(); lit("new_p_1", 0, 1, 0);
    cyc(); lit("new_p_2", 0, 2, 0);
    cyc(); lit("new_p_wrap", 0, 0, 1);

    // restart together with step at addr 2
    cyc(); cyc();
    lit("before_rs", 0, 2, 0);
    restart[0] = 1;
    cyc(); lit("restart_step", 0, 0, 0);
    restart[0] = 0;

    // disabled voice holds 0
    ch_en[0] = 0;
    for (int i = 0; i < 3; i++) begin cyc(); lit("disabled", 0, 0, 0); end

    // 1-in-3 strobe, P=2 NORM
    ch_en[0] = 1; step_en = 0; set_ch(0, 2, 1); restart[0] = 1;
    cyc(); restart[0] = 0;
    k = 0;
    for (int i = 0; i < 9; i++) begin
      step_en = (i % 3 == 0);
      if (step_en) k++;
      cyc();
      lit("strobe", 0, k % 3, (step_en && k % 3 == 0) ? 1 : 0);
    end

    // L=1: addr stays 0, wrap on each strobe
    step_en = 0; set_ch(0, 0, 1); restart[0] = 1;
    cyc(); restart[0] = 0;
    for (int i = 0; i < 6; i++) begin
      step_en = (i % 3 == 0);
      cyc();
      lit("len1", 0, 0, step_en ? 1 : 0);
    end

    // async reset mid-period, ch3 P=1023 DN2
    step_en = 0; ch_en = 4'b1111; set_ch(3, 1023, 3); restart[3] = 1;
    cyc(); restart[3] = 0; step_en = 1;
    for (int i = 0; i < 5; i++) cyc();
    lit("pre_reset", 3, 5, 0);
    #2 rst = 1'b1;
    #1;
    for (int c = 0; c < NCH; c++) lit("async_rst", c, 0, 0);
    cyc();
    rst = 1'b0; step_en = 0; restart = 4'b1111;
    set_ch(0, 3, 1); set_ch(1, 7, 0); set_ch(2, 1, 3);
    cyc(); restart = '0; step_en = 1;
    cyc(); lit("first_step", 3, 1, 0);
    nwrap = 0; wrap_at = -1;
    for (int i = 2; i <= 4096; i++) begin
      if (i == 4096) lit("last_addr", 3, 4095, 0);
      cyc();
      if (wrap[3]) begin nwrap++; wrap_at = i; end
    end
    checks++;
    if (nwrap != 1 || wrap_at != 4096) begin
      errors++;
      $display("FAIL long_wrap got count %0d at step %0d want count 1 at step 4096", nwrap, wrap_at);
    end
    lit("long_end", 3, 0, 1);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      step_en = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NCH; c++) begin
        ch_en[c]   = ($urandom_range(0, 19) != 0);
        restart[c] = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 3) == 0)
          set_ch(c, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023)
                                                 : $urandom_range(0, 12),
                 $urandom_range(0, 3));
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
